// File: rtl/usr_defs.sv
// Shared definitions for universal_shift_register: mode encodings, FSM states
// and the start-acceptance rule. Rotate modes are enabled by `define USR_ROTATE_EN.
package usr_defs;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ASR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ROR  = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_t;

    // A multi-step run may only repeat a shifting/rotating mode.
    function automatic logic is_step_mode(input logic [2:0] m);
`ifdef USR_ROTATE_EN
        return (m >= MODE_SHL) && (m <= MODE_ROR);
`else
        return (m >= MODE_SHL) && (m <= MODE_ASR);
`endif
    endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational single-step next-value function of the universal shift register.
// Rotate modes exist only when USR_ROTATE_EN is defined; otherwise they hold.
module usr_step_logic
    import usr_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic [WIDTH-1:0] load_val,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] next_val
);

    always_comb begin
        next_val = cur_val;
        case (mode)
            MODE_HOLD: next_val = cur_val;
            MODE_LOAD: next_val = load_val;
            MODE_SHL:  next_val = {cur_val[WIDTH-2:0], sin_r};
            MODE_SHR:  next_val = {sin_l, cur_val[WIDTH-1:1]};
            MODE_ASR:  next_val = {cur_val[WIDTH-1], cur_val[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            MODE_ROL:  next_val = {cur_val[WIDTH-2:0], cur_val[WIDTH-1]};
            MODE_ROR:  next_val = {cur_val[0], cur_val[WIDTH-1:1]};
`else
            MODE_ROL:  next_val = cur_val;
            MODE_ROR:  next_val = cur_val;
`endif
            MODE_CLR:  next_val = '0;
            default:   next_val = cur_val;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with single-step and multi-step (start/shamt)
// operation. Optional rotate modes via `define USR_ROTATE_EN.
module universal_shift_register
    import usr_defs::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CW-1:0]    shamt,
    input  logic [WIDTH-1:0] d_in,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] d_out,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    usr_state_t       state_reg;
    logic [2:0]       run_mode_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] step_val;
    logic [2:0]       step_mode;
    logic             busy_reg;
    logic             done_reg;
    logic             start_ok;

    // One step engine serves both the IDLE en path and every RUN step.
    assign step_mode = (state_reg == ST_RUN) ? run_mode_reg : mode;

    usr_step_logic #(.WIDTH(WIDTH)) u_step (
        .cur_val  (d_reg),
        .load_val (d_in),
        .mode     (step_mode),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .next_val (step_val)
    );

    assign start_ok   = start && is_step_mode(mode);
    assign count_next = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            run_mode_reg <= MODE_HOLD;
            count_reg    <= '0;
            d_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        // Accepting a start performs no step on this edge.
                        run_mode_reg <= mode;
                        count_reg    <= count_next;
                        if (count_next == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end else if (en) begin
                        d_reg <= step_val;
                    end
                end
                ST_RUN: begin
                    d_reg     <= step_val;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign d_out    = d_reg;
    assign sout_msb = d_reg[WIDTH-1];
    assign sout_lsb = d_reg[0];
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register: directed plus random stimulus,
// expectations from an arithmetic model, compared by a negedge monitor.
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [CW-1:0] shamt = '0;
    logic [W-1:0]  d_in = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [W-1:0]  d_out;
    logic          sout_msb;
    logic          sout_lsb;
    logic          busy;
    logic          done;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .start    (start),
        .mode     (mode),
        .shamt    (shamt),
        .d_in     (d_in),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .d_out    (d_out),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] v;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    int m_val  = 0;
    bit m_busy = 0;
    int m_left = 0;
    int m_mode = 0;
    bit m_done = 0;

    function automatic int apply(input int v, input int md, input int sl, input int sr, input int d);
        case (md)
            1: return d;
            2: return ((v * 2) + sr) % 256;
            3: return (v / 2) + sl * 128;
            4: return (v / 2) + ((v >= 128) ? 128 : 0);
            5: return ROT_EN ? ((v * 2) % 256 + v / 128) : v;
            6: return ROT_EN ? ((v / 2) + (v % 2) * 128) : v;
            7: return 0;
            default: return v;
        endcase
    endfunction

    function automatic bit accepted(input int md);
        return (md >= 2 && md <= 4) || (ROT_EN && (md == 5 || md == 6));
    endfunction

    task automatic model_edge();
        exp_t e;
        if (m_busy) begin
            m_val  = apply(m_val, m_mode, int'(sin_l), int'(sin_r), int'(d_in));
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_left == 0) m_busy = 0;
        end else begin
            m_done = 0;
            if (start && accepted(int'(mode))) begin
                m_mode = int'(mode);
                m_left = (int'(shamt) > W) ? W : int'(shamt);
                if (m_left == 0) m_done = 1;
                else m_busy = 1;
            end else if (en) begin
                m_val = apply(m_val, int'(mode), int'(sin_l), int'(sin_r), int'(d_in));
            end
        end
        e.v    = W'(m_val);
        e.busy = m_busy;
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the expected post-edge state is queued at the edge.
    task automatic drive(input bit e_i, input bit s_i, input logic [2:0] md, input logic [CW-1:0] sh,
                         input logic [W-1:0] d, input bit sl, input bit sr);
        @(negedge clk);
        #1;
        en = e_i; start = s_i; mode = md; shamt = sh; d_in = d; sin_l = sl; sin_r = sr;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 3'd0, '0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: d_out=%h busy=%b done=%b, required d_out=00 busy=0 done=0",
                     d_out, busy, done);
        end
        m_val = 0; m_busy = 0; m_left = 0; m_done = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: every registered output is compared once per edge with the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (d_out !== mon_e.v || busy !== mon_e.busy || done !== mon_e.done ||
                sout_msb !== mon_e.v[W-1] || sout_lsb !== mon_e.v[0]) begin
                failures++;
                $display("FAIL cycle_check t=%0t: d_out=%h busy=%b done=%b msb=%b lsb=%b, required d_out=%h busy=%b done=%b",
                         $time, d_out, busy, done, sout_msb, sout_lsb, mon_e.v, mon_e.busy, mon_e.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset();
        // Load, then single steps
        drive(1, 0, 3'd1, '0, 8'hA5, 0, 0);
        drive(1, 0, 3'd2, '0, 8'h00, 0, 1);   // SHL -> 4B
        drive(1, 0, 3'd1, '0, 8'hA5, 0, 0);
        drive(1, 0, 3'd3, '0, 8'h00, 0, 0);   // SHR -> 52
        drive(1, 0, 3'd1, '0, 8'h80, 0, 0);
        drive(1, 0, 3'd4, '0, 8'h00, 1, 1);   // ASR -> C0
        // Multi-step ROL by 3 from 81
        drive(1, 0, 3'd1, '0, 8'h81, 0, 0);
        drive(0, 1, 3'd5, 4'd3, 8'h00, 0, 0);
        idle(5);
        // shamt = 0
        drive(0, 1, 3'd2, 4'd0, 8'h00, 0, 0);
        idle(2);
        // shamt = 8 SHL from FF, with run-protection stimulus during the run
        drive(1, 0, 3'd1, '0, 8'hFF, 0, 0);
        drive(0, 1, 3'd2, 4'd8, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 3'd7, 4'd3, 8'h00, 0, 0);
        idle(2);
        // Saturated shamt (12 -> 8 steps) with SHR
        drive(1, 0, 3'd1, '0, 8'h5A, 0, 0);
        drive(0, 1, 3'd3, 4'd12, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 3'd0, '0, 8'h00, i[0], 0);
        // Reset at step 2 of a 5-step run
        drive(1, 0, 3'd1, '0, 8'h3C, 0, 0);
        drive(0, 1, 3'd2, 4'd5, 8'h00, 0, 1);
        drive(0, 0, 3'd0, '0, 8'h00, 0, 1);
        drive(0, 0, 3'd0, '0, 8'h00, 0, 1);
        do_reset();
        idle(6);
        // Back-to-back runs: start held high, re-accepted in each done cycle
        drive(1, 0, 3'd1, '0, 8'h96, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 3'd4, 4'd2, 8'h00, 0, 0);
        idle(2);
        // Randomised phase
        for (int i = 0; i < 300; i++) begin
            drive(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)), CW'($urandom_range(0, 10)),
                  8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)));
        end
        idle(12);
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
